// File: rtl/multicycle_control.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback,
// handshakes with variable-latency IMEM/DMEM, and reports sticky faults.
//
// state  | meaning
// FETCH  | IMEM request outstanding, ir loads on ack
// DECODE | single cycle, illegal encodings trap here
// EXEC   | ALU_out valid, branch target and store address latched
// MEM    | DMEM request outstanding, byte enables driven for stores
// WB     | PC update and register write strobes
// FAULT  | absorbing until reset
module multicycle_control #(
    parameter int XLEN          = 32,
    parameter int MAX_WAIT      = 15,
    parameter int TRAP_ILLEGAL  = 1,
    parameter int TRAP_MISALIGN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic            imem_ack,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] ALU_out,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            pc_we,
    output logic [2:0]      B_Target,
    output logic            MemToReg,
    output logic [3:0]      ALUOp,
    output logic [3:0]      dwe,
    output logic            RegWrite,
    output logic [2:0]      ALU_rv1,
    output logic [2:0]      ALU_rv2,
    output logic [2:0]      state,
    output logic            fault,
    output logic [1:0]      fault_cause
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Counter must hold MAX_WAIT; keep at least one bit when the timeout is disabled.
    localparam int             WCW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

    state_t         state_q, state_d;
    logic [31:0]    ir_q, ir_d;
    logic [2:0]     br_tgt_q, br_tgt_d;
    logic [1:0]     addr_lo_q, addr_lo_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           fault_q, fault_d;
    logic [1:0]     fault_cause_q, fault_cause_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic       illegal, writes_rd, alu_zero, br_taken, timeout;
    logic       unused_ir_bits;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);
    assign illegal   = !(is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store | is_opimm | is_op)
                     | (is_branch & (funct3[2:1] == 2'b01))
                     | (is_store & (funct3 > 3'd2));
    assign writes_rd = (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op)
                     & (ir_q[11:7] != 5'd0);
    assign alu_zero  = (ALU_out == '0);
    // Timeout only fires in the cycle the counter already sits at the limit, so a same-cycle ack wins.
    assign timeout   = (MAX_WAIT > 0) && (wait_cnt_q == WAIT_LIM);
    assign unused_ir_bits = ^{ir_q[31], ir_q[29:15]};

    // Halfword needs bit0 clear; word (and the reserved size) needs both low bits clear.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) & a[0]) | (f3[1] & (a != 2'b00));
    endfunction

    // Datapath steering decoded from the registered instruction.
    always_comb begin
        ALUOp   = 4'b0000;
        ALU_rv1 = 3'b100;
        ALU_rv2 = 3'b100;
        case (opcode)
            OPC_LUI:   begin ALU_rv1 = 3'b010; ALU_rv2 = 3'b010; end
            OPC_AUIPC: begin ALU_rv1 = 3'b001; ALU_rv2 = 3'b010; end
            OPC_JAL, OPC_JALR: begin ALU_rv1 = 3'b001; ALU_rv2 = 3'b001; end
            OPC_LOAD, OPC_STORE: ALU_rv2 = 3'b010;
            OPC_OPIMM: begin
                ALU_rv2 = 3'b010;
                ALUOp   = ((funct3 == 3'b101) && ir_q[30]) ? 4'b1101 : {1'b0, funct3};
            end
            OPC_OP: ALUOp = {ir_q[30], funct3};
            OPC_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   ALUOp = 4'b1000;
                    2'b10:   ALUOp = 4'b0010;
                    2'b11:   ALUOp = 4'b0011;
                    default: ALUOp = 4'b0000;
                endcase
            end
            default: ;
        endcase
    end

    // Branch resolution from the ALU compare result (SUB for eq/ne, SLT/SLTU otherwise).
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:                 br_taken = alu_zero;
            3'b001, 3'b100, 3'b110: br_taken = !alu_zero;
            3'b101, 3'b111:         br_taken = alu_zero;
            default:                br_taken = 1'b0;
        endcase
    end

    // Next-state and strobe generation; reset gates every strobe combinationally.
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        br_tgt_d      = br_tgt_q;
        addr_lo_d     = addr_lo_q;
        wait_cnt_d    = wait_cnt_q;
        fault_d       = fault_q;
        fault_cause_d = fault_cause_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        pc_we         = 1'b0;
        RegWrite      = 1'b0;
        MemToReg      = 1'b0;
        dwe           = 4'b0000;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT; fault_d = 1'b1; fault_cause_d = 2'b11;
                end else if (wait_cnt_q != WAIT_LIM) begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            S_DECODE: begin
                if (illegal && (TRAP_ILLEGAL != 0)) begin
                    state_d = S_FAULT; fault_d = 1'b1; fault_cause_d = 2'b01;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                addr_lo_d = ALU_out[1:0];
                br_tgt_d  = 3'b100;
                state_d   = S_WB;
                if (!illegal) begin
                    if (is_jal || (is_branch && br_taken)) br_tgt_d = 3'b010;
                    else if (is_jalr)                      br_tgt_d = 3'b001;
                    if (is_load || is_store) begin
                        if (misaligned(funct3, ALU_out[1:0]) && (TRAP_MISALIGN != 0)) begin
                            state_d = S_FAULT; fault_d = 1'b1; fault_cause_d = 2'b10;
                        end else begin
                            state_d    = S_MEM;
                            wait_cnt_d = '0;
                        end
                    end
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (is_store && !misaligned(funct3, addr_lo_q)) begin
                    case (funct3[1:0])
                        2'b00:   dwe = 4'b0001 << addr_lo_q;
                        2'b01:   dwe = 4'b0011 << addr_lo_q;
                        default: dwe = 4'b1111;
                    endcase
                end
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (timeout) begin
                    state_d = S_FAULT; fault_d = 1'b1; fault_cause_d = 2'b11;
                end else if (wait_cnt_q != WAIT_LIM) begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            S_WB: begin
                pc_we      = 1'b1;
                RegWrite   = writes_rd && !illegal;
                MemToReg   = is_load;
                state_d    = S_FETCH;
                wait_cnt_d = '0;
            end
            default: state_d = S_FAULT;
        endcase
        if (reset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            pc_we    = 1'b0;
            RegWrite = 1'b0;
            dwe      = 4'b0000;
        end
    end

    // State and context registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            ir_q          <= 32'h0000_0013;
            br_tgt_q      <= 3'b100;
            addr_lo_q     <= 2'b00;
            wait_cnt_q    <= '0;
            fault_q       <= 1'b0;
            fault_cause_q <= 2'b00;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            br_tgt_q      <= br_tgt_d;
            addr_lo_q     <= addr_lo_d;
            wait_cnt_q    <= wait_cnt_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    assign B_Target    = br_tgt_q;
    assign state       = state_q;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;
endmodule
